// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (p0) and load unit (p1).
// Optional RAW scoreboard built when WB_ARB_SCOREBOARD_EN is defined.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic [4:0]            p0_rd,
    input  logic [DATA_WIDTH-1:0] p0_data,
    output logic                  p0_ready,
    input  logic                  p1_valid,
    input  logic [4:0]            p1_rd,
    input  logic [DATA_WIDTH-1:0] p1_data,
    output logic                  p1_ready,
    output logic [4:0]            rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic                  rf_wen,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            chk_a1,
    input  logic [4:0]            chk_a2,
    output logic                  chk_busy
);

    // prio = 0 favours port 0 under contention, 1 favours port 1
    logic prio;
    logic grant0, grant1;

    always_comb begin
        grant0 = !reset && p0_valid && (!p1_valid || !prio);
        grant1 = !reset && p1_valid && (!p0_valid ||  prio);
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Write stage: one committed write per cycle, x0 requests handshake but never enable
    always_ff @(posedge clk) begin
        if (reset) begin
            prio   <= 1'b0;
            rf_wen <= 1'b0;
            rf_a3  <= '0;
            rf_wd  <= '0;
        end else if (grant0) begin
            prio   <= 1'b1;
            rf_wen <= (p0_rd != 5'd0);
            rf_a3  <= p0_rd;
            rf_wd  <= p0_data;
        end else if (grant1) begin
            prio   <= 1'b0;
            rf_wen <= (p1_rd != 5'd0);
            rf_a3  <= p1_rd;
            rf_wd  <= p1_data;
        end else begin
            rf_wen <= 1'b0;
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    logic [31:1] pending;
    logic [31:1] pending_nxt;
    logic [31:0] pending_full;

    // Clear from the committing write first, then apply the issue so a same-edge set wins
    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < 32; i++) begin
            if (rf_wen && (rf_a3 == 5'(i)))
                pending_nxt[i] = 1'b0;
            if (issue_valid && (issue_rd == 5'(i)))
                pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign pending_full = {pending, 1'b0};

    always_comb begin
        chk_busy = !reset &&
                   (((chk_a1 != 5'd0) && pending_full[chk_a1]) ||
                    ((chk_a2 != 5'd0) && pending_full[chk_a2]));
    end
`else
    logic unused_sb;
    assign unused_sb = ^{issue_valid, issue_rd, chk_a1, chk_a2};
    assign chk_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (scoreboard checks follow WB_ARB_SCOREBOARD_EN).
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p1_valid, p0_ready, p1_ready;
    logic [4:0]  p0_rd, p1_rd, rf_a3, issue_rd, chk_a1, chk_a2;
    logic [31:0] p0_data, p1_data, rf_wd;
    logic        rf_wen, issue_valid, chk_busy;
    int          checks = 0;
    int          errors = 0;

    writeback_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
        .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wen(rf_wen),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_busy(chk_busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p0_rd = 0; p0_data = 0;
        p1_valid = 0; p1_rd = 0; p1_data = 0;
        issue_valid = 0; issue_rd = 0; chk_a1 = 0; chk_a2 = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs();
        step(); step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        p0_valid = 1; p1_valid = 1; p0_rd = 5'd3; p1_rd = 5'd4; chk_a1 = 5'd3;
        step(); step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
        checks++; if (rf_a3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got %0d exp 0", rf_a3); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h exp 0", rf_wd); end
        checks++; if ({p0_ready, p1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {p0_ready, p1_ready}); end
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", chk_busy); end
        reset = 0; idle_inputs();
        step();
    endtask

    task automatic test_single_port();
        do_reset();
        p0_valid = 1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
        #1;
        checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {p0_ready, p1_ready}); end
        step();
        p0_valid = 0;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL single_wen got %b exp 1", rf_wen); end
        checks++; if (rf_a3 !== 5'd5) begin errors++; $display("FAIL single_a3 got %0d exp 5", rf_a3); end
        checks++; if (rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wd got %h exp deadbeef", rf_wd); end
        step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL single_wen_off got %b exp 0", rf_wen); end
        checks++; if (rf_a3 !== 5'd5) begin errors++; $display("FAIL single_a3_hold got %0d exp 5", rf_a3); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [4:0] exp_a3  [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
        logic [31:0] exp_wd [4] = '{32'hA0, 32'hB1, 32'hA0, 32'hB1};
        do_reset();
        p0_valid = 1; p0_rd = 5'd1; p0_data = 32'hA0;
        p1_valid = 1; p1_rd = 5'd2; p1_data = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({p0_ready, p1_ready} !== exp_rdy[i]) begin errors++; $display("FAIL contend_ready[%0d] got %b exp %b", i, {p0_ready, p1_ready}, exp_rdy[i]); end
            step();
            checks++; if ({rf_wen, rf_a3} !== {1'b1, exp_a3[i]}) begin errors++; $display("FAIL contend_a3[%0d] got wen=%b a3=%0d exp wen=1 a3=%0d", i, rf_wen, rf_a3, exp_a3[i]); end
            checks++; if (rf_wd !== exp_wd[i]) begin errors++; $display("FAIL contend_wd[%0d] got %h exp %h", i, rf_wd, exp_wd[i]); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_x0_write();
        do_reset();
        p1_valid = 1; p1_rd = 5'd0; p1_data = 32'h1234;
        #1;
        checks++; if ({p0_ready, p1_ready} !== 2'b01) begin errors++; $display("FAIL x0_ready got %b exp 01", {p0_ready, p1_ready}); end
        step();
        p1_valid = 0;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b exp 0", rf_wen); end
        checks++; if (rf_wd !== 32'h1234) begin errors++; $display("FAIL x0_wd got %h exp 1234", rf_wd); end
        step();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen2 got %b exp 0", rf_wen); end
    endtask

`ifdef WB_ARB_SCOREBOARD_EN
    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1; issue_rd = 5'd7; chk_a1 = 5'd0; chk_a2 = 5'd7;
        #1;
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL sb_c0 got %b exp 0", chk_busy); end
        step();
        issue_valid = 0;
        checks++; if (chk_busy !== 1'b1) begin errors++; $display("FAIL sb_c1 got %b exp 1", chk_busy); end
        step();
        checks++; if (chk_busy !== 1'b1) begin errors++; $display("FAIL sb_c2 got %b exp 1", chk_busy); end
        step();
        p0_valid = 1; p0_rd = 5'd7; p0_data = 32'h77;
        #1;
        checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL sb_c3_ready got %b exp 1", p0_ready); end
        step();
        p0_valid = 0;
        checks++; if ({rf_wen, chk_busy} !== 2'b11) begin errors++; $display("FAIL sb_c4 got wen=%b busy=%b exp 1 1", rf_wen, chk_busy); end
        step();
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL sb_c5 got %b exp 0", chk_busy); end
        chk_a1 = 5'd7; chk_a2 = 5'd0;
        #1;
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL sb_a1_clear got %b exp 0", chk_busy); end
    endtask

    task automatic test_collision();
        do_reset();
        chk_a1 = 5'd9;
        issue_valid = 1; issue_rd = 5'd9;
        step();
        issue_valid = 0;
        p0_valid = 1; p0_rd = 5'd9; p0_data = 32'h99;
        step();
        p0_valid = 0;
        issue_valid = 1; issue_rd = 5'd9;
        checks++; if ({rf_wen, rf_a3} !== {1'b1, 5'd9}) begin errors++; $display("FAIL coll_wen got wen=%b a3=%0d exp 1 9", rf_wen, rf_a3); end
        step();
        issue_valid = 0;
        checks++; if (chk_busy !== 1'b1) begin errors++; $display("FAIL coll_set_wins got %b exp 1", chk_busy); end
        p1_valid = 1; p1_rd = 5'd9; p1_data = 32'h9A;
        step();
        p1_valid = 0;
        step();
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL coll_final_clear got %b exp 0", chk_busy); end
    endtask
`else
    task automatic test_scoreboard_off();
        do_reset();
        issue_valid = 1; issue_rd = 5'd7; chk_a1 = 5'd7; chk_a2 = 5'd7;
        step();
        issue_valid = 0;
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL sb_off_busy got %b exp 0", chk_busy); end
        step();
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL sb_off_busy2 got %b exp 0", chk_busy); end
    endtask
`endif

    task automatic test_reset_mid_op();
        do_reset();
        // p0 wins a single grant so prio points at port 1 before the reset
        p0_valid = 1; p0_rd = 5'd4; p0_data = 32'h44;
        issue_valid = 1; issue_rd = 5'd3; chk_a1 = 5'd3;
        step();
        issue_valid = 0;
        p0_rd = 5'd3; p0_data = 32'h33;
        reset = 1;
        #1;
        checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", p0_ready); end
        step();
        reset = 0; p0_valid = 0;
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL midrst_wen got %b exp 0", rf_wen); end
        checks++; if (chk_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", chk_busy); end
        p0_valid = 1; p0_rd = 5'd1; p0_data = 32'h11;
        p1_valid = 1; p1_rd = 5'd2; p1_data = 32'h22;
        #1;
        checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL midrst_prio got %b exp 10", {p0_ready, p1_ready}); end
        step();
        idle_inputs();
        checks++; if (rf_a3 !== 5'd1) begin errors++; $display("FAIL midrst_a3 got %0d exp 1", rf_a3); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_port();
        test_contention();
        test_x0_write();
`ifdef WB_ARB_SCOREBOARD_EN
        test_scoreboard();
        test_collision();
`else
        test_scoreboard_off();
`endif
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
